rr_grant_data_router: RTL and testbench

- Downstream stage of the 4-requester round-robin arbiter.
- Consumes the arbiter's one-hot GNT and the four requesters' payload words.
- Moves the granted requester's word into a 2-entry output FIFO toward a shared sink using a valid/ready handshake.
- Returns a per-requester ACK pulse for each captured word and tags every word with its source and its beat index within the current grant tenure.

---
 rtl/rr_grant_data_router.sv | 126 ++++++++++++
 tb/tb_rr_grant_data_router.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_data_router.sv
// Routes the granted requester's payload into a 2-entry output FIFO, tagging each word
// with its source and beat-within-tenure, and returns a one-cycle ACK per captured word.
module rr_grant_data_router #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        GNT,
    input  logic [DATA_W-1:0] REQ_DATA0,
    input  logic [DATA_W-1:0] REQ_DATA1,
    input  logic [DATA_W-1:0] REQ_DATA2,
    input  logic [DATA_W-1:0] REQ_DATA3,
    output logic [3:0]        ACK,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_src,
    output logic [1:0]        out_beat,
    output logic [1:0]        fifo_level,
    output logic              gnt_err
);

    logic [DATA_W-1:0] req_data [4];
    assign req_data[0] = REQ_DATA0;
    assign req_data[1] = REQ_DATA1;
    assign req_data[2] = REQ_DATA2;
    assign req_data[3] = REQ_DATA3;

    logic [2:0] gnt_count;
    logic [1:0] src;
    logic       gnt_ok;
    logic       gnt_multi;

    always_comb begin
        gnt_count = '0;
        src       = '0;
        for (int i = 0; i < 4; i++) begin
            if (GNT[i]) begin
                gnt_count = gnt_count + 3'd1;
                src       = 2'(i);
            end
        end
    end

    assign gnt_ok    = (gnt_count == 3'd1);
    assign gnt_multi = (gnt_count >= 3'd2);

    logic [DATA_W-1:0] mem_data_reg [2];
    logic [1:0]        mem_src_reg  [2];
    logic [1:0]        mem_beat_reg [2];
    logic              rd_ptr_reg;
    logic              wr_ptr_reg;
    logic [1:0]        level_reg;
    logic [3:0]        ack_reg;
    logic              err_reg;
    logic [1:0]        last_src_reg;
    logic [1:0]        last_beat_reg;
    logic              prev_ok_reg;

    logic       pop;
    logic       push;
    logic       restart;
    logic [1:0] beat_next;
    logic [3:0] ack_next;

    assign pop       = (level_reg != 2'd0) && out_ready;
    assign push      = gnt_ok && ((level_reg < 2'd2) || pop);
    // A tenure continues only across back-to-back valid grants to the same source.
    assign restart   = !prev_ok_reg || (src != last_src_reg);
    assign beat_next = restart ? 2'd0 : last_beat_reg + 2'd1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_ack
        assign ack_next[gi] = push && (src == 2'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_data_reg[i] <= '0;
                mem_src_reg[i]  <= '0;
                mem_beat_reg[i] <= '0;
            end
            rd_ptr_reg    <= 1'b0;
            wr_ptr_reg    <= 1'b0;
            level_reg     <= 2'd0;
            ack_reg       <= 4'b0000;
            err_reg       <= 1'b0;
            last_src_reg  <= 2'd0;
            last_beat_reg <= 2'd0;
            prev_ok_reg   <= 1'b0;
        end else begin
            if (push) begin
                mem_data_reg[wr_ptr_reg] <= req_data[src];
                mem_src_reg[wr_ptr_reg]  <= src;
                mem_beat_reg[wr_ptr_reg] <= beat_next;
                wr_ptr_reg               <= ~wr_ptr_reg;
                last_beat_reg            <= beat_next;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 2'd1;
                2'b01:   level_reg <= level_reg - 2'd1;
                default: level_reg <= level_reg;
            endcase
            ack_reg <= ack_next;
            if (gnt_ok) begin
                last_src_reg <= src;
            end
            prev_ok_reg <= gnt_ok;
            if (gnt_multi) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign out_valid  = (level_reg != 2'd0);
    assign out_data   = mem_data_reg[rd_ptr_reg];
    assign out_src    = mem_src_reg[rd_ptr_reg];
    assign out_beat   = mem_beat_reg[rd_ptr_reg];
    assign fifo_level = level_reg;
    assign ACK        = ack_reg;
    assign gnt_err    = err_reg;

endmodule

// File: tb/tb_rr_grant_data_router.sv
// Directed vector table, hand-written corner sequences and random stimulus for
// rr_grant_data_router, all cross-checked against a queue-based reference model.
module tb_rr_grant_data_router;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        GNT;
    logic [DATA_W-1:0] REQ_DATA0, REQ_DATA1, REQ_DATA2, REQ_DATA3;
    logic [3:0]        ACK;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_src;
    logic [1:0]        out_beat;
    logic [1:0]        fifo_level;
    logic              gnt_err;

    rr_grant_data_router #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .GNT(GNT),
        .REQ_DATA0(REQ_DATA0), .REQ_DATA1(REQ_DATA1),
        .REQ_DATA2(REQ_DATA2), .REQ_DATA3(REQ_DATA3),
        .ACK(ACK), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src), .out_beat(out_beat),
        .fifo_level(fifo_level), .gnt_err(gnt_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] data;
        logic       ready;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [1:0] exp_src;
        logic [1:0] exp_beat;
        logic [1:0] exp_level;
        logic [3:0] exp_ack;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic [1:0] s;
        logic [1:0] b;
    } ent_t;

    // Reference model: a queue of tagged words plus tenure bookkeeping.
    ent_t       mq[$];
    int         m_last_src;
    bit         m_prev_ok;
    int         m_last_beat;
    logic [3:0] m_ack;
    bit         m_err;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][7:0] spread(logic [3:0] g, logic [7:0] d);
        logic [3:0][7:0] r;
        for (int i = 0; i < 4; i++) r[i] = g[i] ? d : 8'(8'hE0 + i);
        return r;
    endfunction

    task automatic model_check();
        chk("m_level", 32'(fifo_level), 32'(mq.size()));
        chk("m_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("m_ack", 32'(ACK), 32'(m_ack));
        chk("m_err", 32'(gnt_err), 32'(m_err));
        if (mq.size() > 0) begin
            chk("m_data", 32'(out_data), 32'(mq[0].d));
            chk("m_src", 32'(out_src), 32'(mq[0].s));
            chk("m_beat", 32'(out_beat), 32'(mq[0].b));
        end
    endtask

    task automatic step(logic r, logic [3:0] g, logic [3:0][7:0] dall, logic rdy);
        int  ones;
        int  s;
        bit  pop;
        bit  push;
        int  beat;
        ent_t e;
        rst = r; GNT = g; out_ready = rdy;
        REQ_DATA0 = dall[0]; REQ_DATA1 = dall[1]; REQ_DATA2 = dall[2]; REQ_DATA3 = dall[3];
        ones = $countones(g);
        s = 0;
        for (int i = 0; i < 4; i++) if (g[i]) s = i;
        if (r) begin
            mq.delete();
            m_ack = 4'b0; m_err = 0; m_prev_ok = 0; m_last_src = 0; m_last_beat = 0;
        end else begin
            pop  = (mq.size() > 0) && rdy;
            push = (ones == 1) && ((mq.size() < 2) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                beat = (!m_prev_ok || s != m_last_src) ? 0 : (m_last_beat + 1) % 4;
                e.d = dall[s]; e.s = 2'(s); e.b = 2'(beat);
                mq.push_back(e);
                m_last_beat = beat;
            end
            m_ack = push ? 4'(1 << s) : 4'b0;
            if (ones == 1) m_last_src = s;
            m_prev_ok = (ones == 1);
            if (ones >= 2) m_err = 1;
        end
        @(posedge clk);
        #1;
        model_check();
        $display("cyc rst=%0b gnt=%b rdy=%0b -> valid=%0b data=%h src=%0d beat=%0d lvl=%0d ack=%b err=%0b",
                 r, g, rdy, out_valid, out_data, out_src, out_beat, fifo_level, ACK, gnt_err);
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1; GNT = 4'b0; out_ready = 1'b0;
        REQ_DATA0 = '0; REQ_DATA1 = '0; REQ_DATA2 = '0; REQ_DATA3 = '0;
        mq.delete(); m_ack = 4'b0; m_err = 0; m_prev_ok = 0; m_last_src = 0; m_last_beat = 0;

        step(1'b1, 4'b0000, spread(4'b0, 8'h00), 1'b0);
        step(1'b1, 4'b0000, spread(4'b0, 8'h00), 1'b0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ack", 32'(ACK), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_src", 32'(out_src), 0);
        chk("rst_beat", 32'(out_beat), 0);
        chk("rst_err", 32'(gnt_err), 0);

        // gnt, data, ready | valid, data, src, beat, level, ack
        vecs.push_back('{4'b0001, 8'hA0, 1, 1, 8'hA0, 0, 0, 1, 4'b0001});
        vecs.push_back('{4'b0001, 8'hA1, 1, 1, 8'hA1, 0, 1, 1, 4'b0001});
        vecs.push_back('{4'b0001, 8'hA2, 1, 1, 8'hA2, 0, 2, 1, 4'b0001});
        vecs.push_back('{4'b0001, 8'hA3, 1, 1, 8'hA3, 0, 3, 1, 4'b0001});
        vecs.push_back('{4'b0001, 8'hA4, 1, 1, 8'hA4, 0, 0, 1, 4'b0001});
        vecs.push_back('{4'b0000, 8'h00, 1, 0, 8'h00, 0, 0, 0, 4'b0000});
        vecs.push_back('{4'b0010, 8'hB0, 1, 1, 8'hB0, 1, 0, 1, 4'b0010});
        vecs.push_back('{4'b0010, 8'hB1, 1, 1, 8'hB1, 1, 1, 1, 4'b0010});
        vecs.push_back('{4'b0010, 8'hB2, 1, 1, 8'hB2, 1, 2, 1, 4'b0010});
        vecs.push_back('{4'b0010, 8'hB3, 1, 1, 8'hB3, 1, 3, 1, 4'b0010});
        vecs.push_back('{4'b0100, 8'hC0, 1, 1, 8'hC0, 2, 0, 1, 4'b0100});
        vecs.push_back('{4'b0000, 8'h00, 1, 0, 8'h00, 0, 0, 0, 4'b0000});
        vecs.push_back('{4'b1000, 8'h10, 0, 1, 8'h10, 3, 0, 1, 4'b1000});
        vecs.push_back('{4'b1000, 8'h11, 0, 1, 8'h10, 3, 0, 2, 4'b1000});
        vecs.push_back('{4'b1000, 8'h12, 0, 1, 8'h10, 3, 0, 2, 4'b0000});
        vecs.push_back('{4'b1000, 8'h12, 0, 1, 8'h10, 3, 0, 2, 4'b0000});
        vecs.push_back('{4'b1000, 8'h12, 1, 1, 8'h11, 3, 1, 2, 4'b1000});
        vecs.push_back('{4'b1000, 8'h13, 1, 1, 8'h12, 3, 2, 2, 4'b1000});
        vecs.push_back('{4'b0000, 8'h00, 1, 1, 8'h13, 3, 3, 1, 4'b0000});
        vecs.push_back('{4'b0000, 8'h00, 1, 0, 8'h00, 0, 0, 0, 4'b0000});

        foreach (vecs[k]) begin
            step(1'b0, vecs[k].gnt, spread(vecs[k].gnt, vecs[k].data), vecs[k].ready);
            chk($sformatf("v%0d_valid", k), 32'(out_valid), 32'(vecs[k].exp_valid));
            chk($sformatf("v%0d_level", k), 32'(fifo_level), 32'(vecs[k].exp_level));
            chk($sformatf("v%0d_ack", k), 32'(ACK), 32'(vecs[k].exp_ack));
            if (vecs[k].exp_valid) begin
                chk($sformatf("v%0d_data", k), 32'(out_data), 32'(vecs[k].exp_data));
                chk($sformatf("v%0d_src", k), 32'(out_src), 32'(vecs[k].exp_src));
                chk($sformatf("v%0d_beat", k), 32'(out_beat), 32'(vecs[k].exp_beat));
            end
        end

        // Full FIFO with simultaneous pop and push from requester 0.
        step(1'b0, 4'b0001, spread(4'b0001, 8'h31), 1'b0);
        step(1'b0, 4'b0001, spread(4'b0001, 8'h32), 1'b0);
        chk("full_level", 32'(fifo_level), 2);
        step(1'b0, 4'b0001, spread(4'b0001, 8'h33), 1'b1);
        chk("pp_level", 32'(fifo_level), 2);
        chk("pp_head", 32'(out_data), 32'h32);
        chk("pp_ack", 32'(ACK), 32'b0001);
        step(1'b0, 4'b0000, spread(4'b0000, 8'h00), 1'b1);
        step(1'b0, 4'b0000, spread(4'b0000, 8'h00), 1'b1);
        chk("drain_level", 32'(fifo_level), 0);

        // Multi-bit grant: no capture, sticky error until reset.
        step(1'b0, 4'b0011, spread(4'b0011, 8'h55), 1'b1);
        chk("bad_ack", 32'(ACK), 0);
        chk("bad_level", 32'(fifo_level), 0);
        chk("bad_err", 32'(gnt_err), 1);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'b0001, spread(4'b0001, 8'(8'h60 + k)), 1'b1);
            chk("err_sticky", 32'(gnt_err), 1);
            if (k == 0) chk("bad_restart_beat", 32'(out_beat), 0);
        end
        step(1'b1, 4'b0000, spread(4'b0000, 8'h00), 1'b0);
        chk("err_cleared", 32'(gnt_err), 0);

        // Reset while full discards both words.
        step(1'b0, 4'b0010, spread(4'b0010, 8'h21), 1'b0);
        step(1'b0, 4'b0010, spread(4'b0010, 8'h22), 1'b0);
        chk("pre_rst_level", 32'(fifo_level), 2);
        step(1'b1, 4'b0010, spread(4'b0010, 8'h23), 1'b0);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_ack", 32'(ACK), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        step(1'b0, 4'b0010, spread(4'b0010, 8'h24), 1'b1);
        chk("post_rst_beat", 32'(out_beat), 0);
        chk("post_rst_data", 32'(out_data), 32'h24);
        chk("post_rst_ack", 32'(ACK), 32'b0010);

        // Randomized traffic; grants tend to repeat to build multi-beat tenures.
        begin
            logic [3:0] g;
            logic [3:0] g_prev;
            int         sel;
            g_prev = 4'b0001;
            for (int k = 0; k < 400; k++) begin
                sel = $urandom_range(0, 19);
                if (sel < 8)       g = g_prev;
                else if (sel < 15) g = 4'(1 << $urandom_range(0, 3));
                else if (sel < 18) g = 4'b0000;
                else               g = 4'($urandom_range(0, 15)) | 4'b0101;
                if ($countones(g) == 1) g_prev = g;
                step(($urandom_range(0, 59) == 0), g, 32'($urandom), 1'($urandom_range(0, 2) != 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
